// File: rtl/lut2_resp_checker.sv
// lut2_resp_checker: downstream response checker for the CC_LUT2 array.
// Compares each 80-bit response against a golden model of the 80 LUT2
// instances. It counts accepted vectors and mismatching vectors, and
// records the first failure. It reports pass/fail after NUM_VECTORS beats.
// Optional feature: define LUT2CHK_MISR_EN to build a 32-bit MISR over the
// committed responses. Without it, signature is tied to 0.
//
// state | meaning
// IDLE  | waiting for start, results from reset
// RUN   | accepting beats until NUM_VECTORS have been taken
// DRAIN | two cycles letting the 2-stage compare pipeline empty
// DONE  | results held, start re-arms a fresh run

module lut2_resp_checker #(
   parameter int NUM_VECTORS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] stim,
   input  logic [79:0] resp,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] vec_cnt,
   output logic [15:0] err_cnt,
   output logic [15:0] first_err_vec,
   output logic [6:0]  first_err_bit,
   output logic [31:0] signature
);

   localparam logic [15:0] NV       = 16'(NUM_VECTORS);
   localparam logic [63:0] EXP_HIGH = 64'hFEDC_BA98_7654_3210;
   localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        drain_cnt;
   logic        accept;
   logic        run_entry;
   logic        last_beat;

   logic        s1_valid;
   logic [31:0] s1_stim;
   logic [79:0] s1_resp;
   logic [15:0] s1_idx;
   logic        s2_valid;
   logic [79:0] s2_mis;
   logic [15:0] s2_idx;
   logic        have_err;

   logic [79:0] exp_vec;
   logic [6:0]  low_bit;

   assign accept    = in_valid && in_ready;
   assign run_entry = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last_beat = accept && ((17'(vec_cnt) + 17'd1) == 17'(NV));

   // State register and drain-cycle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RUN;
         ST_RUN:   if ((NV == 16'd0) || last_beat) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_cnt) state_nxt = ST_DONE;
         ST_DONE:  if (start) state_nxt = ST_RUN;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      in_ready = (state == ST_RUN) && (NV != 16'd0);
      busy     = (state == ST_RUN) || (state == ST_DRAIN);
      done     = (state == ST_DONE);
      pass     = (state == ST_DONE) && (err_cnt == 16'd0);
   end

   // Golden model: low 16 LUTs use their index as INIT, the upper 64 are constants
   always_comb begin
      logic [3:0] init;
      init    = 4'd0;
      exp_vec = {EXP_HIGH, 16'h0000};
      for (int i = 0; i < 16; i++) begin
         init       = 4'(i);
         exp_vec[i] = init[s1_stim[2*i +: 2]];
      end
   end

   // Lowest mismatching bit of the vector in stage 2
   always_comb begin
      low_bit = 7'd0;
      for (int i = 79; i >= 0; i--) begin
         if (s2_mis[i]) low_bit = 7'(i);
      end
   end

`ifdef LUT2CHK_MISR_EN
   logic [79:0] s2_resp;
   logic [31:0] sig;
   logic [31:0] sig_nxt;

   // MISR step for the vector leaving stage 2
   always_comb begin
      sig_nxt = {sig[30:0], 1'b0}
              ^ (sig[31] ? 32'h0040_0007 : 32'h0)
              ^ s2_resp[31:0] ^ s2_resp[63:32] ^ {16'h0, s2_resp[79:64]};
   end

   // Signature register, seeded on reset and at the start of every run
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_resp <= '0;
         sig     <= SIG_SEED;
      end else begin
         s2_resp <= s1_resp;
         if (run_entry)     sig <= SIG_SEED;
         else if (s2_valid) sig <= sig_nxt;
      end
   end

   assign signature = sig;
`else
   assign signature = 32'h0;
`endif

   // Compare pipeline and result accumulation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid      <= 1'b0;
         s1_stim       <= '0;
         s1_resp       <= '0;
         s1_idx        <= '0;
         s2_valid      <= 1'b0;
         s2_mis        <= '0;
         s2_idx        <= '0;
         vec_cnt       <= '0;
         err_cnt       <= '0;
         first_err_vec <= '0;
         first_err_bit <= '0;
         have_err      <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_stim <= stim;
            s1_resp <= resp;
            s1_idx  <= vec_cnt;
         end
         s2_valid <= s1_valid;
         s2_mis   <= s1_valid ? (s1_resp ^ exp_vec) : '0;
         s2_idx   <= s1_idx;

         if (run_entry) begin
            vec_cnt       <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            first_err_bit <= '0;
            have_err      <= 1'b0;
         end else begin
            if (accept) vec_cnt <= vec_cnt + 16'd1;
            if (s2_valid && (s2_mis != '0)) begin
               if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
               if (!have_err) begin
                  have_err      <= 1'b1;
                  first_err_vec <= s2_idx;
                  first_err_bit <= low_bit;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lut2_resp_checker.sv
// Directed bench for lut2_resp_checker with NUM_VECTORS=4, plus a second
// instance with NUM_VECTORS=0 that must never accept a beat.
module tb_lut2_resp_checker;

   localparam logic [63:0] C_HI = 64'hFEDCBA9876543210;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [31:0] stim;
   logic [79:0] resp;

   logic        in_ready, busy, done, pass;
   logic [15:0] vec_cnt, err_cnt, first_err_vec;
   logic [6:0]  first_err_bit;
   logic [31:0] signature;

   logic        z_in_ready, z_busy, z_done, z_pass;
   logic [15:0] z_vec_cnt, z_err_cnt, z_first_err_vec;
   logic [6:0]  z_first_err_bit;
   logic [31:0] z_signature;
   logic        z_rdy_seen = 1'b0;

   int tests = 0;
   int fails = 0;

   lut2_resp_checker #(.NUM_VECTORS(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .stim(stim), .resp(resp), .busy(busy),
      .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
      .first_err_vec(first_err_vec), .first_err_bit(first_err_bit),
      .signature(signature)
   );

   lut2_resp_checker #(.NUM_VECTORS(0)) u_zero (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(z_in_ready), .stim(stim), .resp(resp), .busy(z_busy),
      .done(z_done), .pass(z_pass), .vec_cnt(z_vec_cnt), .err_cnt(z_err_cnt),
      .first_err_vec(z_first_err_vec), .first_err_bit(z_first_err_bit),
      .signature(z_signature)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (z_in_ready) z_rdy_seen <= 1'b1;

   typedef struct {
      logic [31:0] stim;
      logic [79:0] good;
      logic [79:0] bad;
      logic [3:0]  mask;
      int          err;
      int          fvec;
      int          fbit;
      logic        pass_exp;
   } vec_t;

   vec_t tbl[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

`ifdef LUT2CHK_MISR_EN
   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [79:0] r);
      logic [31:0] f;
      f = r[31:0] ^ r[63:32] ^ {16'h0, r[79:64]};
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ f;
   endfunction
`endif

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check("done_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic check_sig(input logic [31:0] model);
`ifdef LUT2CHK_MISR_EN
      check("signature", signature, model);
`else
      check("signature", signature, 32'h0 & model);
`endif
   endtask

   initial begin
      int n;
      int acc;
      logic [31:0] sig_m;
      logic [79:0] r;

      tbl[0] = '{32'h0, {C_HI, 16'hAAAA}, {C_HI, 16'hAAAA}, 4'b0000, 0, 0, 0, 1'b1};
      tbl[1] = '{32'h0, {C_HI, 16'hAAAA},
                 {C_HI, 16'hAAAA} ^ (80'd1 << 17) ^ (80'd1 << 40), 4'b0100, 1, 2, 17, 1'b0};
      tbl[2] = '{32'hFFFFFFFF, {C_HI, 16'hFF00}, {C_HI, 16'hFF00}, 4'b0000, 0, 0, 0, 1'b1};
      tbl[3] = '{32'hFFFFFFFF, {C_HI, 16'hFF00}, {C_HI, 16'hAAAA}, 4'b0001, 1, 0, 1, 1'b0};
      tbl[4] = '{32'h0, {C_HI, 16'hAAAA},
                 {C_HI, 16'hAAAA} ^ (80'd1 << 79) ^ (80'd1 << 70), 4'b1010, 2, 1, 70, 1'b0};
      tbl[5] = '{32'h55555555, {C_HI, 16'hCCCC},
                 {C_HI, 16'hCCCC} ^ (80'd1 << 16), 4'b1111, 4, 0, 16, 1'b0};

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; stim = '0; resp = '0;
      tick();
      tick();
      rst_n = 1'b1;

      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_vec_cnt", {16'd0, vec_cnt}, 32'd0);
      check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("rst_first_err_vec", {16'd0, first_err_vec}, 32'd0);
      check("rst_first_err_bit", {25'd0, first_err_bit}, 32'd0);
      check_sig(32'hFFFFFFFF);

      // in_valid while idle must not be counted
      stim = 32'h0; resp = {C_HI, 16'hAAAA};
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("idle_vec_cnt", {16'd0, vec_cnt}, 32'd0);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);

      // start, then toggle in_valid every cycle, with an ignored start mid-run
      pulse_start();
      in_valid = 1'b0;
      acc = 0;
      n = 0;
      while (acc < 4 && n < 40) begin
         in_valid = ~in_valid;
         start = (n == 3);
         if (in_valid && in_ready) acc++;
         tick();
         n++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      check("toggle_accepts", acc, 4);
      wait_done(n);
      check("toggle_vec_cnt", {16'd0, vec_cnt}, 32'd4);
      check("toggle_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("toggle_pass", {31'd0, pass}, 32'd1);

      // table of 4-beat back-to-back runs
      for (int t = 0; t < 6; t++) begin
         pulse_start();
         sig_m = 32'hFFFFFFFF;
         for (int b = 0; b < 4; b++) begin
            r = tbl[t].mask[b] ? tbl[t].bad : tbl[t].good;
`ifdef LUT2CHK_MISR_EN
            sig_m = misr_step(sig_m, r);
`endif
            check($sformatf("t%0d_ready_b%0d", t, b), {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1; stim = tbl[t].stim; resp = r;
            tick();
         end
         in_valid = 1'b0;
         check($sformatf("t%0d_drain_busy", t), {31'd0, busy & ~in_ready}, 32'd1);
         wait_done(n);
         check($sformatf("t%0d_done_latency", t), n, 2);
         check($sformatf("t%0d_pass", t), {31'd0, pass}, {31'd0, tbl[t].pass_exp});
         check($sformatf("t%0d_vec_cnt", t), {16'd0, vec_cnt}, 32'd4);
         check($sformatf("t%0d_err_cnt", t), {16'd0, err_cnt}, tbl[t].err);
         if (tbl[t].err != 0) begin
            check($sformatf("t%0d_first_vec", t), {16'd0, first_err_vec}, tbl[t].fvec);
            check($sformatf("t%0d_first_bit", t), {25'd0, first_err_bit}, tbl[t].fbit);
         end
         check_sig(sig_m);
      end

      // reset after 2 of 4 beats, then a clean run
      pulse_start();
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; stim = 32'h0; resp = {C_HI, 16'h0000};
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_vec_cnt", {16'd0, vec_cnt}, 32'd0);
      tick();
      tick();
      check("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check_sig(32'hFFFFFFFF);
      pulse_start();
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1; stim = 32'h0; resp = {C_HI, 16'hAAAA};
         tick();
      end
      in_valid = 1'b0;
      wait_done(n);
      check("post_rst_pass", {31'd0, pass}, 32'd1);
      check("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("post_rst_vec_cnt", {16'd0, vec_cnt}, 32'd4);

      // NUM_VECTORS=0 instance never accepts and finishes
      for (int i = 0; i < 4; i++) tick();
      check("zero_ready_seen", {31'd0, z_rdy_seen}, 32'd0);
      check("zero_done", {31'd0, z_done}, 32'd1);
      check("zero_vec_cnt", {16'd0, z_vec_cnt}, 32'd0);
      check("zero_pass", {31'd0, z_pass}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
